instr_fetch_decode: RTL and testbench

Upstream pipeline stage that feeds the register-file/write-back stage. Holds a 16-entry × 32-bit instruction memory loaded over a simple write port. Once started, it fetches one instruction per cycle from a 4-bit wrapping PC, splits each word into the operand fields the write-back stage consumes, and registers them. It supports downstream stall (bubble insertion) and halt.

---
 rtl/instr_fetch_decode_if.sv | 38 +++
 rtl/instr_fetch_decode.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_decode.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_decode_if.sv
// Bus between the instruction fetch/decode stage and its neighbours:
// the memory load port, run control, and the decoded operand fields.
interface instr_fetch_decode_if #(
   parameter int INSTR_W = 32,
   parameter int AW      = 4
);
   logic               load_en;
   logic [AW-1:0]      load_addr;
   logic [INSTR_W-1:0] load_data;
   logic               start;
   logic               stall;
   logic               halt_req;

   logic               busy;
   logic               valid;
   logic [AW-1:0]      pc_out;
   logic [3:0]         op_code;
   logic [3:0]         dest;
   logic [3:0]         op_reg1;
   logic               imm_or_reg;
   logic [3:0]         sft_imm;
   logic [7:0]         imm;
   logic [7:0]         sft_reg;
   logic [3:0]         op_reg2;
   logic [15:0]        issue_cnt;

   modport master (
      output load_en, load_addr, load_data, start, stall, halt_req,
      input  busy, valid, pc_out, op_code, dest, op_reg1, imm_or_reg,
             sft_imm, imm, sft_reg, op_reg2, issue_cnt
   );

   modport slave (
      input  load_en, load_addr, load_data, start, stall, halt_req,
      output busy, valid, pc_out, op_code, dest, op_reg1, imm_or_reg,
             sft_imm, imm, sft_reg, op_reg2, issue_cnt
   );
endinterface

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode stage: 16-word program memory, wrapping PC,
// registered operand fields with stall bubbles and halt back to IDLE.
module instr_fetch_decode #(
   parameter int INSTR_W = 32,
   parameter int DEPTH   = 16
) (
   input logic                  clk,
   input logic                  rst,
   instr_fetch_decode_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [INSTR_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]      pc_q, pc_d;
   logic               busy_q, busy_d;
   logic               valid_q, valid_d;
   logic [AW-1:0]      pc_out_q, pc_out_d;
   logic [3:0]         op_code_q, op_code_d;
   logic [3:0]         dest_q, dest_d;
   logic [3:0]         op_reg1_q, op_reg1_d;
   logic               imm_or_reg_q, imm_or_reg_d;
   logic [3:0]         sft_imm_q, sft_imm_d;
   logic [7:0]         imm_q, imm_d;
   logic [7:0]         sft_reg_q, sft_reg_d;
   logic [3:0]         op_reg2_q, op_reg2_d;
   logic [15:0]        issue_cnt_q, issue_cnt_d;

   logic [INSTR_W-1:0] instr;
   logic               unused_rsvd;

   assign instr       = mem_q[pc_q];
   assign unused_rsvd = ^instr[18:12];

   always_comb begin
      state_d      = state_q;
      mem_d        = mem_q;
      pc_d         = pc_q;
      valid_d      = valid_q;
      pc_out_d     = pc_out_q;
      op_code_d    = op_code_q;
      dest_d       = dest_q;
      op_reg1_d    = op_reg1_q;
      imm_or_reg_d = imm_or_reg_q;
      sft_imm_d    = sft_imm_q;
      imm_d        = imm_q;
      sft_reg_d    = sft_reg_q;
      op_reg2_d    = op_reg2_q;
      issue_cnt_d  = issue_cnt_q;

      unique case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            // A same-cycle load lands before the first fetch reads memory.
            if (bus.load_en) begin
               mem_d[bus.load_addr] = bus.load_data;
            end
            if (bus.start) begin
               pc_d        = '0;
               issue_cnt_d = '0;
               state_d     = RUN;
            end
         end
         RUN: begin
            if (bus.halt_req) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end else if (bus.stall) begin
               valid_d = 1'b0;
            end else begin
               valid_d      = 1'b1;
               pc_out_d     = pc_q;
               pc_d         = pc_q + AW'(1);
               op_code_d    = instr[31:28];
               dest_d       = instr[27:24];
               op_reg1_d    = instr[23:20];
               imm_or_reg_d = instr[19];
               // Operand fields of the unused flavour are zeroed per instruction.
               sft_imm_d    = instr[19] ? instr[11:8] : 4'h0;
               imm_d        = instr[19] ? instr[7:0]  : 8'h00;
               sft_reg_d    = instr[19] ? 8'h00       : instr[11:4];
               op_reg2_d    = instr[19] ? 4'h0        : instr[3:0];
               if (issue_cnt_q != 16'hFFFF) begin
                  issue_cnt_d = issue_cnt_q + 16'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         pc_q         <= '0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         pc_out_q     <= '0;
         op_code_q    <= '0;
         dest_q       <= '0;
         op_reg1_q    <= '0;
         imm_or_reg_q <= 1'b0;
         sft_imm_q    <= '0;
         imm_q        <= '0;
         sft_reg_q    <= '0;
         op_reg2_q    <= '0;
         issue_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         mem_q        <= mem_d;
         pc_q         <= pc_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
         pc_out_q     <= pc_out_d;
         op_code_q    <= op_code_d;
         dest_q       <= dest_d;
         op_reg1_q    <= op_reg1_d;
         imm_or_reg_q <= imm_or_reg_d;
         sft_imm_q    <= sft_imm_d;
         imm_q        <= imm_d;
         sft_reg_q    <= sft_reg_d;
         op_reg2_q    <= op_reg2_d;
         issue_cnt_q  <= issue_cnt_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.valid      = valid_q;
   assign bus.pc_out     = pc_out_q;
   assign bus.op_code    = op_code_q;
   assign bus.dest       = dest_q;
   assign bus.op_reg1    = op_reg1_q;
   assign bus.imm_or_reg = imm_or_reg_q;
   assign bus.sft_imm    = sft_imm_q;
   assign bus.imm        = imm_q;
   assign bus.sft_reg    = sft_reg_q;
   assign bus.op_reg2    = op_reg2_q;
   assign bus.issue_cnt  = issue_cnt_q;
endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed and randomized bench for instr_fetch_decode against a cycle-level
// behavioural model of the fetch/decode rules.
module tb_instr_fetch_decode;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_decode_if bus ();
   instr_fetch_decode dut (.clk(clk), .rst(rst), .bus(bus));

   int tests = 0;
   int fails = 0;

   // Model: program, run flag, next PC, issue count, last issued word.
   logic [31:0] m_mem [16];
   logic        m_run;
   logic [3:0]  m_pc;
   logic [15:0] m_cnt;
   logic [31:0] e_word;
   logic [3:0]  e_pc;
   logic        e_valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
      m_run = 1'b0; m_pc = 4'h0; m_cnt = 16'h0;
      e_word = 32'h0; e_pc = 4'h0; e_valid = 1'b0;
   endtask

   task automatic check_all(input string tag);
      logic im;
      im = e_word[19];
      chk({tag, ".busy"},       bus.busy,       m_run);
      chk({tag, ".valid"},      bus.valid,      e_valid);
      chk({tag, ".pc_out"},     bus.pc_out,     e_pc);
      chk({tag, ".op_code"},    bus.op_code,    e_word[31:28]);
      chk({tag, ".dest"},       bus.dest,       e_word[27:24]);
      chk({tag, ".op_reg1"},    bus.op_reg1,    e_word[23:20]);
      chk({tag, ".imm_or_reg"}, bus.imm_or_reg, im);
      chk({tag, ".sft_imm"},    bus.sft_imm,    im ? e_word[11:8] : 4'h0);
      chk({tag, ".imm"},        bus.imm,        im ? e_word[7:0]  : 8'h0);
      chk({tag, ".sft_reg"},    bus.sft_reg,    im ? 8'h0 : e_word[11:4]);
      chk({tag, ".op_reg2"},    bus.op_reg2,    im ? 4'h0 : e_word[3:0]);
      chk({tag, ".issue_cnt"},  bus.issue_cnt,  m_cnt);
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic cyc(input logic le, input logic [3:0] la, input logic [31:0] ld,
                      input logic st, input logic sl, input logic hr, input string tag);
      bus.load_en = le; bus.load_addr = la; bus.load_data = ld;
      bus.start = st; bus.stall = sl; bus.halt_req = hr;
      if (!m_run) begin
         e_valid = 1'b0;
         if (le) m_mem[la] = ld;
         if (st) begin m_pc = 4'h0; m_cnt = 16'h0; m_run = 1'b1; end
      end else if (hr) begin
         m_run = 1'b0; e_valid = 1'b0;
      end else if (sl) begin
         e_valid = 1'b0;
      end else begin
         e_word = m_mem[m_pc]; e_pc = m_pc; e_valid = 1'b1;
         m_pc = 4'((m_pc + 1) % 16);
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [3:0] a;
      bus.load_en = 1'b0; bus.load_addr = 4'h0; bus.load_data = 32'h0;
      bus.start = 1'b0; bus.stall = 1'b0; bus.halt_req = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      @(posedge clk); #1;
      rst = 1'b1;

      // Immediate and register operand decode
      cyc(1'b1, 4'h0, 32'h1238_0A55, 1'b0, 1'b0, 1'b0, "load0");
      cyc(1'b1, 4'h1, 32'h4560_0F27, 1'b0, 1'b0, 1'b0, "load1");
      cyc(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, "start");
      chk("start.busy_hi", bus.busy, 1'b1);
      cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, "fetch0");
      chk("imm.valid", bus.valid, 1'b1);
      chk("imm.pc_out", bus.pc_out, 4'h0);
      chk("imm.op_code", bus.op_code, 4'h1);
      chk("imm.dest", bus.dest, 4'h2);
      chk("imm.op_reg1", bus.op_reg1, 4'h3);
      chk("imm.imm_or_reg", bus.imm_or_reg, 1'b1);
      chk("imm.sft_imm", bus.sft_imm, 4'hA);
      chk("imm.imm", bus.imm, 8'h55);
      chk("imm.sft_reg", bus.sft_reg, 8'h00);
      chk("imm.op_reg2", bus.op_reg2, 4'h0);
      cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, "fetch1");
      chk("reg.imm_or_reg", bus.imm_or_reg, 1'b0);
      chk("reg.sft_reg", bus.sft_reg, 8'hF2);
      chk("reg.op_reg2", bus.op_reg2, 4'h7);
      chk("reg.imm", bus.imm, 8'h00);
      chk("reg.sft_imm", bus.sft_imm, 4'h0);
      cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, "halt1");
      chk("halt1.busy_lo", bus.busy, 1'b0);

      // Wrap-around over all 16 entries
      for (int i = 0; i < 16; i++) begin
         a = 4'(i);
         cyc(1'b1, a, {a, 28'h0}, 1'b0, 1'b0, 1'b0, "wrload");
      end
      cyc(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, "wrstart");
      for (int k = 0; k < 17; k++) begin
         cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, "wrap");
         chk("wrap.pc_seq", bus.pc_out, k % 16);
         chk("wrap.op_seq", bus.op_code, k % 16);
      end
      chk("wrap.issue_cnt17", bus.issue_cnt, 16'd17);

      // Stall bubbles at pc_out 5
      for (int k = 0; k < 5; k++) cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, "to5");
      chk("to5.pc_out", bus.pc_out, 4'h5);
      for (int k = 0; k < 2; k++) begin
         cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, "stall");
         chk("stall.valid_lo", bus.valid, 1'b0);
         chk("stall.pc_hold", bus.pc_out, 4'h5);
      end
      cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, "unstall");
      chk("unstall.pc_out", bus.pc_out, 4'h6);
      chk("unstall.valid", bus.valid, 1'b1);

      // Loads during RUN are ignored; halt beats stall
      cyc(1'b1, 4'h7, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, "runload");
      cyc(1'b1, 4'h8, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, "prio");
      chk("prio.busy_lo", bus.busy, 1'b0);
      chk("prio.valid_lo", bus.valid, 1'b0);
      cyc(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, "restart");
      for (int k = 0; k < 9; k++) begin
         cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, "memkeep");
         chk("memkeep.op_code", bus.op_code, k);
      end

      // Asynchronous reset mid-stall, then memory must read back as zero
      cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, "prerst");
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge clk); #1;
      check_all("rst_hold");
      rst = 1'b1;
      cyc(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, "rststart");
      for (int k = 0; k < 4; k++) cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, "rsrun");
      chk("mem3.pc_out", bus.pc_out, 4'h3);
      chk("mem3.op_code", bus.op_code, 4'h0);
      chk("mem3.valid", bus.valid, 1'b1);

      // Load and start together, then start and halt together
      cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, "halt2");
      cyc(1'b1, 4'h0, 32'h9ABC_0123, 1'b1, 1'b0, 1'b0, "ldstart");
      cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, "ldfetch");
      chk("ldfetch.op_code", bus.op_code, 4'h9);
      chk("ldfetch.imm", bus.imm, 8'h23);
      cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, "halt3");
      cyc(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, "start_halt");
      chk("start_halt.busy", bus.busy, 1'b1);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         cyc(($urandom_range(0, 9) < 3), 4'($urandom_range(0, 15)), $urandom,
             ($urandom_range(0, 9) < 2), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 19) == 0), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
